// File: rtl/mac_sequencer.sv
// mac_sequencer: job controller for one mac_unit processing element.
// Clears the accumulator, streams `length` operand pairs into the MAC,
// waits out the MAC result latency, then offers the captured result on a
// valid/ready output. The sequencer does no arithmetic; it only flags
// results that sit on the saturation rails.
module mac_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 20,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    // job control
    input  logic                     start,
    input  logic [LEN_W-1:0]         length,
    input  logic                     abort,
    output logic                     busy,
    // operand stream
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic signed [DATA_W-1:0] op_weight,
    input  logic signed [DATA_W-1:0] op_input,
    // MAC processing element
    output logic                     mac_enable,
    output logic                     mac_clear_acc,
    output logic signed [DATA_W-1:0] mac_weight,
    output logic signed [DATA_W-1:0] mac_input,
    input  logic signed [ACC_W-1:0]  mac_accumulator,
    // result stream
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data,
    output logic                     res_saturated
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_t;

    // Drain counter runs 0..MAC_LAT-1; the last value marks the capture edge.
    localparam int                     DRAIN_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [DRAIN_W-1:0]     DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   r_state;
    state_t                   w_next;
    logic [LEN_W-1:0]         r_len;
    logic [LEN_W-1:0]         r_beat_cnt;
    logic [DRAIN_W-1:0]       r_drain_cnt;
    logic signed [ACC_W-1:0]  r_res_data;
    logic                     r_res_sat;

    logic                     w_accept;
    logic [LEN_W-1:0]         w_beat_inc;
    logic                     w_last_beat;
    logic                     w_drain_done;

    // A beat moves only in STREAM with the source valid and no abort pending;
    // abort pulls op_ready low so the in-flight beat is never consumed.
    assign w_accept     = (r_state == S_STREAM) && op_valid && !abort;
    assign w_beat_inc   = r_beat_cnt + 1'b1;
    assign w_last_beat  = (w_beat_inc == r_len);
    assign w_drain_done = (r_state == S_DRAIN) && (r_drain_cnt == DRAIN_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every normal transition out of a busy state.
    // NOTE: w_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_next = S_CLEAR;
                S_CLEAR:  w_next = (r_len == '0) ? S_DRAIN : S_STREAM;
                S_STREAM: if (w_accept && w_last_beat) w_next = S_DRAIN;
                S_DRAIN:  if (w_drain_done) w_next = S_RESULT;
                S_RESULT: if (res_ready) w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Output decode: MAC controls and handshakes are pure functions of state
    // (plus the accept qualifier), so reset forces them low immediately.
    always_comb begin
        busy          = (r_state != S_IDLE);
        op_ready      = (r_state == S_STREAM) && !abort;
        mac_enable    = w_accept;
        mac_clear_acc = (r_state == S_CLEAR);
        mac_weight    = w_accept ? op_weight : '0;
        mac_input     = w_accept ? op_input  : '0;
        res_valid     = (r_state == S_RESULT);
        res_data      = r_res_data;
        res_saturated = r_res_sat;
    end

    // Job datapath: length latch, beat/drain counters and result capture.
    // NOTE: every register here is small control/result state, so all of it
    // is reset; there is no storage array that would be better left unreset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_res_data  <= '0;
            r_res_sat   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_len      <= length;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= w_beat_inc;
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end

            if (w_drain_done && !abort) begin
                r_res_data <= mac_accumulator;
                r_res_sat  <= (mac_accumulator == ACC_MAX) ||
                              (mac_accumulator == ACC_MIN);
            end
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural saturating MAC model
// standing in for mac_unit. Jobs come from a vector table; abort and
// mid-job reset are hand-written sequences.
module tb_mac_sequencer;

    logic              clock;
    logic              reset;
    logic              start;
    logic [7:0]        length;
    logic              abort;
    logic              busy;
    logic              op_valid;
    logic              op_ready;
    logic [7:0]        op_weight;
    logic [7:0]        op_input;
    logic              mac_enable;
    logic              mac_clear_acc;
    logic [7:0]        mac_weight;
    logic [7:0]        mac_input;
    logic signed [19:0] acc;
    logic              res_valid;
    logic              res_ready;
    logic [19:0]       res_data;
    logic              res_saturated;

    int n_vec = 0;
    int n_err = 0;

    mac_sequencer #(
        .DATA_W (8),
        .ACC_W  (20),
        .LEN_W  (8),
        .MAC_LAT(1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .length         (length),
        .abort          (abort),
        .busy           (busy),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_weight      (op_weight),
        .op_input       (op_input),
        .mac_enable     (mac_enable),
        .mac_clear_acc  (mac_clear_acc),
        .mac_weight     (mac_weight),
        .mac_input      (mac_input),
        .mac_accumulator(acc),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_saturated  (res_saturated)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Saturating MAC model: one-cycle result latency after an enabled edge.
    function automatic logic signed [19:0] mac_step(input logic signed [19:0] a,
                                                    input logic [7:0] w,
                                                    input logic [7:0] x);
        int s;
        s = int'(a) + int'($signed(w)) * int'($signed(x));
        if (s > 524287)  s = 524287;
        if (s < -524288) s = -524288;
        return 20'(s);
    endfunction

    initial acc = '0;
    always @(posedge clock) begin
        if (mac_clear_acc)   acc <= '0;
        else if (mac_enable) acc <= mac_step(acc, mac_weight, mac_input);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         len;
        int         w0, x0;     // first beat
        int         w1, x1;     // every later beat
        int         gap;        // op_valid-low cycles after the first beat
        int         hold;       // extra cycles res_ready stays low (start pulsed)
        logic [19:0] exp_data;
        logic       exp_sat;
        int         exp_lat;    // cycles from start sample to res_valid
    } vec_t;

    vec_t vecs[9];

    // Entered and left at a negedge (+1 time unit), i.e. inputs may be driven now.
    task automatic run_job(input vec_t v, input string tag);
        int cyc, sent, gap_left, n_clr, n_en, n_rdy, bad, lat;
        bit got, in_gap;
        cyc = 0; sent = 0; gap_left = 0; n_clr = 0; n_en = 0; n_rdy = 0;
        bad = 0; lat = 0; got = 0;
        start = 1'b1; length = 8'(v.len); op_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        for (int t = 0; t < 200 && !got; t++) begin
            in_gap = (gap_left > 0);
            if (sent < v.len && !in_gap) begin
                op_valid  = 1'b1;
                op_weight = (sent == 0) ? 8'(v.w0) : 8'(v.w1);
                op_input  = (sent == 0) ? 8'(v.x0) : 8'(v.x1);
            end else begin
                op_valid  = 1'b0;
                op_weight = 8'h55;
                op_input  = 8'hAA;
            end
            #1;
            if (mac_clear_acc) n_clr++;
            if (mac_enable)    n_en++;
            if (op_ready)      n_rdy++;
            if (mac_enable && (mac_weight !== op_weight || mac_input !== op_input)) bad++;
            if (!mac_enable && (mac_weight !== 8'h0 || mac_input !== 8'h0)) bad++;
            if (in_gap) gap_left--;
            if (op_valid && op_ready) begin
                sent++;
                if (sent == 1) gap_left = v.gap;
            end
            if (res_valid) begin
                got = 1;
                lat = cyc;
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        op_valid = 1'b0;
        check({tag, " res_valid seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " res_data"}, res_data, v.exp_data);
        check({tag, " res_saturated"}, res_saturated, v.exp_sat);
        check({tag, " clear pulses"}, n_clr, 1);
        check({tag, " enable pulses"}, n_en, v.len);
        check({tag, " op_ready cycles"}, n_rdy, (v.len == 0) ? 0 : v.len + v.gap);
        check({tag, " mac operand gating"}, bad, 0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clock);
            start  = (h == 1);
            length = 8'd7;
            #1;
            check({tag, " hold res_valid"}, res_valid, 1'b1);
            check({tag, " hold res_data"}, res_data, v.exp_data);
            check({tag, " hold busy"}, busy, 1'b1);
        end
        // Handshake cycle; a start here must be ignored.
        res_ready = 1'b1;
        start     = (v.hold > 0);
        length    = 8'd7;
        @(negedge clock);
        res_ready = 1'b0;
        start     = 1'b0;
        #1;
        check({tag, " idle after handshake busy"}, busy, 1'b0);
        check({tag, " idle after handshake res_valid"}, res_valid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{len: 1,  w0: 5,    x0: 3,   w1: 0,    x1: 0,   gap: 0, hold: 0, exp_data: 20'd15,    exp_sat: 1'b0, exp_lat: 4};
        vecs[1] = '{len: 2,  w0: 5,    x0: 3,   w1: 2,    x1: 4,   gap: 3, hold: 0, exp_data: 20'd23,    exp_sat: 1'b0, exp_lat: 8};
        vecs[2] = '{len: 40, w0: 127,  x0: 127, w1: 127,  x1: 127, gap: 0, hold: 0, exp_data: 20'h7FFFF, exp_sat: 1'b1, exp_lat: 43};
        vecs[3] = '{len: 40, w0: -128, x0: 127, w1: -128, x1: 127, gap: 0, hold: 0, exp_data: 20'h80000, exp_sat: 1'b1, exp_lat: 43};
        vecs[4] = '{len: 1,  w0: 3,    x0: 4,   w1: 0,    x1: 0,   gap: 0, hold: 4, exp_data: 20'd12,    exp_sat: 1'b0, exp_lat: 4};
        vecs[5] = '{len: 0,  w0: 0,    x0: 0,   w1: 0,    x1: 0,   gap: 0, hold: 0, exp_data: 20'd0,     exp_sat: 1'b0, exp_lat: 3};
        vecs[6] = '{len: 3,  w0: 10,   x0: -10, w1: 1,    x1: 1,   gap: 0, hold: 0, exp_data: 20'hFFF9E, exp_sat: 1'b0, exp_lat: 6};
        vecs[7] = '{len: 1,  w0: -6,   x0: 7,   w1: 0,    x1: 0,   gap: 0, hold: 0, exp_data: 20'hFFFD6, exp_sat: 1'b0, exp_lat: 4};
        vecs[8] = '{len: 1,  w0: 5,    x0: 3,   w1: 0,    x1: 0,   gap: 0, hold: 0, exp_data: 20'd15,    exp_sat: 1'b0, exp_lat: 4};

        reset = 1'b1; start = 1'b0; length = '0; abort = 1'b0;
        op_valid = 1'b0; op_weight = '0; op_input = '0; res_ready = 1'b0;
        @(negedge clock);
        check("reset busy", busy, 1'b0);
        check("reset res_valid", res_valid, 1'b0);
        check("reset res_data", res_data, 20'd0);
        check("reset clear", mac_clear_acc, 1'b0);
        reset = 1'b0;
        #1;

        // Table-driven jobs; row 4 holds res_ready low and pulses start in RESULT,
        // row 5 then starts one cycle after that handshake.
        for (int i = 0; i < 7; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Abort a length-4 job after two beats of (1,1).
        start = 1'b1; length = 8'd4;
        @(negedge clock);                       // CLEAR
        start = 1'b0; op_valid = 1'b1; op_weight = 8'd1; op_input = 8'd1;
        @(negedge clock);                       // beat 1
        @(negedge clock);                       // beat 2
        @(negedge clock);
        abort = 1'b1;
        #1;
        check("abort op_ready", op_ready, 1'b0);
        check("abort mac_enable", mac_enable, 1'b0);
        check("abort busy", busy, 1'b1);
        @(negedge clock);
        abort = 1'b0;
        #1;
        check("post-abort busy", busy, 1'b0);
        check("post-abort op_ready", op_ready, 1'b0);
        check("post-abort res_valid", res_valid, 1'b0);
        check("post-abort mac beats", 32'(acc), 32'd2);
        op_valid = 1'b0;
        @(negedge clock);
        #1;
        check("post-abort idle res_valid", res_valid, 1'b0);
        run_job(vecs[7], "after-abort");

        // Reset in the middle of STREAM.
        start = 1'b1; length = 8'd5;
        @(negedge clock);
        start = 1'b0; op_valid = 1'b1; op_weight = 8'd2; op_input = 8'd2;
        @(negedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("mid-reset busy", busy, 1'b0);
        check("mid-reset op_ready", op_ready, 1'b0);
        check("mid-reset mac_enable", mac_enable, 1'b0);
        check("mid-reset mac_clear_acc", mac_clear_acc, 1'b0);
        check("mid-reset mac_weight", mac_weight, 8'd0);
        check("mid-reset mac_input", mac_input, 8'd0);
        check("mid-reset res_valid", res_valid, 1'b0);
        check("mid-reset res_saturated", res_saturated, 1'b0);
        check("mid-reset res_data", res_data, 20'd0);
        @(negedge clock);
        reset = 1'b0; op_valid = 1'b0;
        #1;
        check("after reset busy", busy, 1'b0);
        run_job(vecs[8], "after-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
